// File: rtl/imem_responder.sv
// Instruction-memory fetch responder: registered-read word memory feeding a 2-entry in-order response FIFO.
// Define IMEM_BOUNDS_CHECK_EN to fault aligned fetches (and drop writes) at or beyond 4*WORDS bytes.
module imem_responder #(
    parameter int          WORDS    = 256,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_instr,
    output logic        resp_fault,
    output logic [63:0] resp_addr,
    input  logic        wr_en,
    input  logic [63:0] wr_addr,
    input  logic [31:0] wr_data
);
    localparam int AW = $clog2(WORDS);

    logic [31:0]   mem [WORDS];
    logic [31:0]   rd_data_reg;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic          misaligned;
    logic          rd_oob;
    logic          wr_ok;
    logic          unused_wr_bits;

    assign rd_idx     = req_addr[AW+1:2];
    assign wr_idx     = wr_addr[AW+1:2];
    assign misaligned = (req_addr[1:0] != 2'b00);

`ifdef IMEM_BOUNDS_CHECK_EN
    assign rd_oob         = |req_addr[63:AW+2];
    assign wr_ok          = ~|wr_addr[63:AW+2];
    assign unused_wr_bits = ^wr_addr[1:0];
`else
    assign rd_oob         = 1'b0;
    assign wr_ok          = 1'b1;
    assign unused_wr_bits = ^{wr_addr[63:AW+2], wr_addr[1:0]};
`endif

    // Stage 1: one read in flight, becomes the response the following cycle.
    logic        inflight_reg;
    logic        inflight_fault_reg;
    logic [63:0] inflight_addr_reg;
    logic [31:0] inflight_instr;

    // Stage 2: two-entry circular response queue.
    logic [31:0] fifo_instr [2];
    logic        fifo_fault [2];
    logic [63:0] fifo_addr  [2];
    logic        wr_ptr_reg;
    logic        rd_ptr_reg;
    logic [1:0]  count_reg;

    logic        fifo_empty;
    logic        accept;
    logic        pop;
    logic        push;
    logic        fifo_pop;
    logic [2:0]  occ_after_pop;
    logic [31:0] head_instr;
    logic        head_fault;
    logic [63:0] head_addr;

    assign inflight_instr = inflight_fault_reg ? NOP_WORD : rd_data_reg;
    assign fifo_empty     = (count_reg == 2'd0);

    assign resp_valid = !rst && (!fifo_empty || inflight_reg);
    assign pop        = resp_valid && resp_ready;
    // An empty queue lets the in-flight read be consumed directly, giving one-cycle latency.
    assign push       = inflight_reg && !(fifo_empty && pop);
    assign fifo_pop   = pop && !fifo_empty;

    assign occ_after_pop = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign req_ready     = !rst && (occ_after_pop < 3'd2);
    assign accept        = req_valid && req_ready;

    assign head_instr = fifo_empty ? inflight_instr    : fifo_instr[rd_ptr_reg];
    assign head_fault = fifo_empty ? inflight_fault_reg : fifo_fault[rd_ptr_reg];
    assign head_addr  = fifo_empty ? inflight_addr_reg  : fifo_addr[rd_ptr_reg];

    assign resp_instr = resp_valid ? head_instr : 32'd0;
    assign resp_fault = resp_valid ? head_fault : 1'b0;
    assign resp_addr  = resp_valid ? head_addr  : 64'd0;

    // Memory has no reset; a write and read of the same word in one cycle yields the old word.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
        if (accept) begin
            rd_data_reg <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr_reg] <= inflight_instr;
            fifo_fault[wr_ptr_reg] <= inflight_fault_reg;
            fifo_addr[wr_ptr_reg]  <= inflight_addr_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg       <= 1'b0;
            inflight_fault_reg <= 1'b0;
            inflight_addr_reg  <= 64'd0;
            wr_ptr_reg         <= 1'b0;
            rd_ptr_reg         <= 1'b0;
            count_reg          <= 2'd0;
        end else begin
            inflight_reg <= accept;
            if (accept) begin
                inflight_fault_reg <= misaligned || rd_oob;
                inflight_addr_reg  <= req_addr;
            end
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            unique case ({push, fifo_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus randomized traffic against a queue model.
module tb_imem_responder;
    localparam int          WORDS = 256;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = 64'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_instr;
    logic        resp_fault;
    logic [63:0] resp_addr;
    logic        wr_en = 1'b0;
    logic [63:0] wr_addr = 64'd0;
    logic [31:0] wr_data = 32'd0;

    always #5 clk = ~clk;

    imem_responder #(.WORDS(WORDS), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_instr(resp_instr), .resp_fault(resp_fault), .resp_addr(resp_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    typedef struct {
        logic [31:0] instr;
        logic        fault;
        logic [63:0] addr;
    } resp_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mdl_mem [WORDS];
    resp_t       exp_q [$];

    function automatic resp_t model_fetch(input logic [63:0] a);
        resp_t r;
        r.addr  = a;
        r.fault = 1'b0;
        r.instr = NOP;
        if ((a % 4) != 0) begin
            r.fault = 1'b1;
`ifdef IMEM_BOUNDS_CHECK_EN
        end else if (a >= 64'(4 * WORDS)) begin
            r.fault = 1'b1;
`endif
        end else begin
            r.instr = mdl_mem[int'((a / 4) % WORDS)];
        end
        return r;
    endfunction

    task automatic drive(input logic r, input logic rv, input logic [63:0] ra, input logic rr,
                         input logic we, input logic [63:0] wa, input logic [31:0] wd);
        @(negedge clk);
        rst = r; req_valid = rv; req_addr = ra; resp_ready = rr;
        wr_en = we; wr_addr = wa; wr_data = wd;
        #1;
    endtask

    // Moves the model across one rising edge using the handshakes visible this cycle.
    task automatic advance();
        resp_t e;
        bit    acc;
        bit    pop;
        acc = req_valid && req_ready;
        pop = resp_valid && resp_ready;
        e   = model_fetch(req_addr);
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
        end else begin
            if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
        end
`ifdef IMEM_BOUNDS_CHECK_EN
        if (wr_en && wr_addr < 64'(4 * WORDS)) mdl_mem[int'((wr_addr / 4) % WORDS)] = wr_data;
`else
        if (wr_en) mdl_mem[int'((wr_addr / 4) % WORDS)] = wr_data;
`endif
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            total++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
                bad++; $display("FAIL reset_hold valid=%0b ready=%0b want 0/0", resp_valid, req_ready);
            end
            total++;
            if (resp_instr !== 32'd0 || resp_fault !== 1'b0 || resp_addr !== 64'd0) begin
                bad++; $display("FAIL reset_outputs instr=%h fault=%0b addr=%h want zeros", resp_instr, resp_fault, resp_addr);
            end
            advance();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL reset_release ready=%0b valid=%0b want 1/0", req_ready, resp_valid);
        end
        advance();
        $display("test_reset done");
    endtask

    task automatic test_program();
        logic [31:0] w [3];
        w[0] = 32'h00500093; w[1] = 32'h00A00113; w[2] = 32'h002081B3;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, 64'h100 + 64'(4 * i), w[i]);
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, i < 3, 64'h100 + 64'(4 * i), 1, 0, 0, 0);
            if (i < 3) begin
                total++;
                if (req_ready !== 1'b1) begin
                    bad++; $display("FAIL prog_ready cyc=%0d got=%0b want=1", i, req_ready);
                end
            end
            if (i >= 1) begin
                total++;
                if (resp_valid !== 1'b1 || resp_instr !== w[i-1] || resp_fault !== 1'b0
                    || resp_addr !== 64'h100 + 64'(4 * (i - 1))) begin
                    bad++; $display("FAIL prog_resp cyc=%0d got v=%0b i=%h f=%0b a=%h want v=1 i=%h f=0 a=%h",
                                    i, resp_valid, resp_instr, resp_fault, resp_addr, w[i-1], 64'h100 + 64'(4 * (i - 1)));
                end
            end
            $display("prog cyc=%0d valid=%0b instr=%h addr=%h", i, resp_valid, resp_instr, resp_addr);
            advance();
        end
        drive(0, 0, 0, 1, 0, 0, 0);
        total++;
        if (resp_valid !== 1'b0) begin
            bad++; $display("FAIL prog_drained got=%0b want=0", resp_valid);
        end
        advance();
    endtask

    task automatic test_backpressure();
        int          acc_cnt = 0;
        logic [63:0] offer   = 64'h100;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, offer, 0, 0, 0, 0);
            if (i >= 2) begin
                total++;
                if (req_ready !== 1'b0) begin
                    bad++; $display("FAIL bp_ready_full cyc=%0d got=%0b want=0", i, req_ready);
                end
            end
            if (i >= 1) begin
                total++;
                if (resp_valid !== 1'b1 || resp_instr !== 32'h00500093 || resp_addr !== 64'h100) begin
                    bad++; $display("FAIL bp_head_stable cyc=%0d got v=%0b i=%h a=%h want v=1 i=00500093 a=100",
                                    i, resp_valid, resp_instr, resp_addr);
                end
            end
            if (req_valid && req_ready) begin
                acc_cnt++;
                offer = offer + 64'd4;
            end
            $display("bp cyc=%0d ready=%0b valid=%0b instr=%h", i, req_ready, resp_valid, resp_instr);
            advance();
        end
        total++;
        if (acc_cnt != 2) begin
            bad++; $display("FAIL bp_accept_count got=%0d want=2", acc_cnt);
        end
        drive(0, 0, 0, 1, 0, 0, 0);
        total++;
        if (req_ready !== 1'b1 || resp_instr !== 32'h00500093) begin
            bad++; $display("FAIL bp_drain0 ready=%0b instr=%h want 1/00500093", req_ready, resp_instr);
        end
        advance();
        drive(0, 0, 0, 1, 0, 0, 0);
        total++;
        if (resp_valid !== 1'b1 || resp_instr !== 32'h00A00113 || resp_addr !== 64'h104) begin
            bad++; $display("FAIL bp_drain1 v=%0b instr=%h addr=%h want 1/00a00113/104", resp_valid, resp_instr, resp_addr);
        end
        advance();
        drive(0, 0, 0, 1, 0, 0, 0);
        total++;
        if (resp_valid !== 1'b0) begin
            bad++; $display("FAIL bp_empty got=%0b want=0", resp_valid);
        end
        advance();
    endtask

    task automatic test_misaligned();
        drive(0, 1, 64'h102, 1, 0, 0, 0);
        advance();
        drive(0, 0, 0, 1, 0, 0, 0);
        total++;
        if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_instr !== NOP || resp_addr !== 64'h102) begin
            bad++; $display("FAIL misaligned v=%0b f=%0b i=%h a=%h want 1/1/%h/102", resp_valid, resp_fault, resp_instr, resp_addr, NOP);
        end
        $display("misaligned fault=%0b instr=%h", resp_fault, resp_instr);
        advance();
    endtask

    task automatic test_bounds();
        logic [31:0] want_i;
        logic        want_f;
        drive(0, 0, 0, 0, 1, 64'h0, 32'h11223344);
        advance();
        drive(0, 1, 64'h400, 1, 0, 0, 0);
        advance();
`ifdef IMEM_BOUNDS_CHECK_EN
        want_i = NOP;          want_f = 1'b1;
`else
        want_i = 32'h11223344; want_f = 1'b0;
`endif
        drive(0, 0, 0, 1, 0, 0, 0);
        total++;
        if (resp_valid !== 1'b1 || resp_fault !== want_f || resp_instr !== want_i) begin
            bad++; $display("FAIL bounds_400 v=%0b f=%0b i=%h want 1/%0b/%h", resp_valid, resp_fault, resp_instr, want_f, want_i);
        end
        $display("bounds 0x400 fault=%0b instr=%h", resp_fault, resp_instr);
        advance();
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 64'h104, 0, 0, 0, 0);
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_accept got=%0b want=1", req_ready);
        end
        advance();
        drive(1, 0, 0, 1, 0, 0, 0);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 0, 0);
            total++;
            if (resp_valid !== 1'b0) begin
                bad++; $display("FAIL rstmid_lost cyc=%0d valid=%0b instr=%h want valid=0", i, resp_valid, resp_instr);
            end
            advance();
        end
        drive(0, 1, 64'h108, 1, 0, 0, 0);
        advance();
        drive(0, 0, 0, 1, 0, 0, 0);
        total++;
        if (resp_valid !== 1'b1 || resp_instr !== 32'h002081B3 || resp_addr !== 64'h108 || resp_fault !== 1'b0) begin
            bad++; $display("FAIL rstmid_next v=%0b i=%h a=%h f=%0b want 1/002081b3/108/0", resp_valid, resp_instr, resp_addr, resp_fault);
        end
        $display("reset_mid next instr=%h addr=%h", resp_instr, resp_addr);
        advance();
    endtask

    task automatic test_random();
        int          occ;
        bit          exp_pop;
        logic [63:0] ra;
        logic [63:0] wa;
        logic        rv;
        logic        rr;
        logic        we;
        int          pops = 0;
        for (int i = 0; i < WORDS; i++) begin
            drive(0, 0, 0, 0, 1, 64'(4 * i), $urandom);
            advance();
        end
        for (int c = 0; c < 1500; c++) begin
            case ($urandom_range(9))
                0:       ra = {$urandom, $urandom};
                1:       ra = 64'(4 * $urandom_range(2 * WORDS - 1) + $urandom_range(3, 1));
                default: ra = 64'(4 * $urandom_range(2 * WORDS - 1));
            endcase
            wa = 64'($urandom_range(8 * WORDS - 1));
            rv = ($urandom_range(9) < 7);
            rr = ($urandom_range(9) < 6);
            we = ($urandom_range(9) < 2);
            drive(0, rv, ra, rr, we, wa, $urandom);
            occ     = exp_q.size();
            exp_pop = (occ > 0) && rr;
            total++;
            if (resp_valid !== (occ > 0)) begin
                bad++; $display("FAIL rand_valid cyc=%0d got=%0b want=%0b", c, resp_valid, occ > 0);
            end
            total++;
            if (req_ready !== ((occ - int'(exp_pop)) < 2)) begin
                bad++; $display("FAIL rand_ready cyc=%0d got=%0b want=%0b", c, req_ready, (occ - int'(exp_pop)) < 2);
            end
            if (occ > 0) begin
                total++;
                if (resp_instr !== exp_q[0].instr || resp_fault !== exp_q[0].fault || resp_addr !== exp_q[0].addr) begin
                    bad++; $display("FAIL rand_resp cyc=%0d got i=%h f=%0b a=%h want i=%h f=%0b a=%h", c,
                                    resp_instr, resp_fault, resp_addr, exp_q[0].instr, exp_q[0].fault, exp_q[0].addr);
                end
                if (exp_pop) pops++;
            end
            advance();
        end
        $display("test_random done responses=%0d", pops);
    endtask

    initial begin
        test_reset();
        test_program();
        test_backpressure();
        test_misaligned();
        test_bounds();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter WORDS, default 256: instruction memory depth in 32-bit words; power of two, 16..4096.
REQ-002 Parameter NOP_WORD, default 32'h00000013: instruction returned on a faulted fetch.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  fetch request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_addr  input  64  byte address of the instruction (the PC).
REQ-008 resp_valid  output  1  response at FIFO head is valid.
REQ-009 resp_ready  input  1  consumer accepts the head response.
REQ-010 resp_instr  output  32  fetched instruction word.
REQ-011 resp_fault  output  1  fetch faulted; resp_instr is NOP_WORD.
REQ-012 resp_addr  output  64  req_addr echoed with its response.
REQ-013 wr_en  input  1  program-load write strobe.
REQ-014 wr_addr  input  64  byte address of the word written; bits [1:0] ignored.
REQ-015 wr_data  input  32  word written.

Function
REQ-016 Request accepted on a cycle where req_valid && req_ready; unaccepted requests are not recorded.
REQ-017 Memory read registered: the response to a request accepted in cycle N enters the response FIFO at the end of cycle N+1, so resp_valid=1 no earlier than cycle N+1 (one-cycle latency when the FIFO is empty).
REQ-018 Response FIFO is 2 entries and in-order; responses are never dropped or reordered.
REQ-019 req_ready = (fifo_count + inflight - pop) < 2, where pop = resp_valid && resp_ready; this combinational path from resp_ready to req_ready is permitted.
REQ-020 With req_valid=1 and resp_ready=1 held, throughput is one response per cycle after the first.
REQ-021 Head entry (instr, fault, addr) is held stable while resp_valid=1 and resp_ready=0.
REQ-022 Word index = req_addr[log2(WORDS)+1:2].
REQ-023 Misaligned request (req_addr[1:0] != 0) -> resp_fault=1, resp_instr=NOP_WORD; the memory value is not returned.
REQ-024 Write occurs when wr_en=1 at the rising edge; a same-cycle read of the same word returns the old data.
REQ-025 Simultaneous push and pop on a full FIFO is legal; count is unchanged.
REQ-026 Memory contents are undefined until written; not cleared by reset.

Reset
REQ-027 While rst=1: FIFO emptied, in-flight read discarded; resp_valid=0, req_ready=0, resp_instr=0, resp_fault=0, resp_addr=0.
REQ-028 First cycle after rst falls: req_ready=1.
REQ-029 Reset mid-operation: queued and in-flight responses are lost; no response is issued for them afterwards.
REQ-030 wr_en during reset still writes memory.

Configuration
REQ-031 Macro IMEM_BOUNDS_CHECK_EN defined: an aligned request with req_addr >= 4*WORDS -> resp_fault=1, resp_instr=NOP_WORD.
REQ-032 Macro IMEM_BOUNDS_CHECK_EN undefined: upper address bits are ignored, the index wraps modulo WORDS, and only misalignment faults.
REQ-033 Writes to out-of-range addresses are ignored when the macro is defined and wrap when it is undefined.

Verification
REQ-034 Reset: rst=1 for 2 cycles, then release -> resp_valid=0 throughout, req_ready=1 on the first cycle after release.
REQ-035 Load words 0x100/0x104/0x108 with 0x00500093/0x00A00113/0x002081B3; request 0x100, 0x104, 0x108 back-to-back with resp_ready=1 -> the same words in order on 3 consecutive cycles, fault=0, resp_addr echoed.
REQ-036 Backpressure: resp_ready=0 while 3 requests are offered -> exactly 2 accepted, req_ready=0, head stable; raising resp_ready drains 2 responses and reopens req_ready.
REQ-037 Misaligned request 0x102 -> resp_fault=1, resp_instr=0x00000013.
REQ-038 WORDS=256, request 0x400: macro defined -> fault=1, NOP; macro undefined -> the word at 0x000 returned, fault=0.
REQ-039 Reset asserted one cycle after acceptance of 0x104 -> no response for 0x104 after rst falls; the next request is served normally.
